mips_control_fsm: RTL and testbench

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

---
 rtl/mips_control_fsm_if.sv | 34 +++
 rtl/mips_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_mips_control_fsm.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_control_fsm_if.sv
// Control bundle between the multicycle controller and the datapath.
// The controller is the master: it consumes instruction and zero_flag, and drives every strobe and select.
interface mips_control_fsm_if #(
    parameter int BUS_WIDTH = 16
);
    logic [BUS_WIDTH-1:0] instruction;
    logic                 zero_flag;
    logic                 InsRead;
    logic                 PCnext;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 ALUSrc;
    logic                 RegWrite;
    logic                 outEn;
    logic [1:0]           RegDst;
    logic [1:0]           PCSrc;
    logic [1:0]           MemtoReg;
    logic [2:0]           ALUControl;
    logic                 halted;
    logic                 illegal;
    logic [2:0]           state_dbg;

    modport master (
        input  instruction, zero_flag,
        output InsRead, PCnext, MemRead, MemWrite, ALUSrc, RegWrite, outEn,
               RegDst, PCSrc, MemtoReg, ALUControl, halted, illegal, state_dbg
    );

    modport slave (
        output instruction, zero_flag,
        input  InsRead, PCnext, MemRead, MemWrite, ALUSrc, RegWrite, outEn,
               RegDst, PCSrc, MemtoReg, ALUControl, halted, illegal, state_dbg
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS-style controller: 3 cycles per instruction, 4 for LW and JAL; outputs registered per state.
// No backpressure: one state per clk; strobes are masked while rst is high.
module mips_control_fsm #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_control_fsm_if.master    bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEMWB  = 3'd3,
        LINK   = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_JAL  = 4'h6;
    localparam logic [3:0] OP_JR   = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic       ins_read;
        logic       pc_next;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       out_en;
        logic [1:0] reg_dst;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_ctl;
        logic       beq;
        logic       halted;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   illegal_q, illegal_d;

    logic [BUS_WIDTH-1:0] instr;
    logic [3:0]           opcode;
    logic [2:0]           funct;
    logic                 unused_instr_bits;

    assign instr             = bus.instruction;
    assign opcode            = instr[15:12];
    assign funct             = instr[2:0];
    assign unused_instr_bits = ^instr[11:3];

    // Output image of a state; EXEC/MEMWB/LINK use the instruction, which is held stable from DECODE on.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [3:0] op, input logic [2:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: c.ins_read = 1'b1;
            EXEC: begin
                case (op)
                    OP_R: begin
                        c.alu_ctl = fn; c.reg_dst = 2'b01; c.reg_write = 1'b1; c.pc_next = 1'b1;
                    end
                    OP_ADDI: begin
                        c.alu_src = 1'b1; c.reg_write = 1'b1; c.pc_next = 1'b1;
                    end
                    OP_LW: begin
                        c.alu_src = 1'b1; c.mem_read = 1'b1;
                    end
                    OP_SW: begin
                        c.alu_src = 1'b1; c.mem_write = 1'b1; c.pc_next = 1'b1;
                    end
                    OP_BEQ: begin
                        c.alu_ctl = 3'b001; c.beq = 1'b1; c.pc_next = 1'b1;
                    end
                    OP_J:   begin c.pc_src = 2'b10; c.pc_next = 1'b1; end
                    OP_JAL: c.pc_next = 1'b1;
                    OP_JR:  begin c.pc_src = 2'b11; c.pc_next = 1'b1; end
                    OP_IN: begin
                        c.mem_to_reg = 2'b11; c.reg_write = 1'b1; c.pc_next = 1'b1;
                    end
                    OP_OUT: begin c.out_en = 1'b1; c.pc_next = 1'b1; end
                    default: c = '0;
                endcase
            end
            MEMWB: begin
                c.alu_src = 1'b1; c.mem_to_reg = 2'b01; c.reg_write = 1'b1; c.pc_next = 1'b1;
            end
            LINK: begin
                c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.reg_write = 1'b1;
                c.pc_src = 2'b10; c.pc_next = 1'b1;
            end
            HALT:    c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                if (opcode inside {[4'hA:4'hE]}) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (opcode)
                    OP_LW:   state_d = MEMWB;
                    OP_JAL:  state_d = LINK;
                    OP_HALT: state_d = HALT;
                    default: state_d = FETCH;
                endcase
            end
            MEMWB:   state_d = FETCH;
            LINK:    state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        ctrl_d = ctrl_for(state_d, opcode, funct);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            ctrl_q    <= ctrl_for(FETCH, 4'h0, 3'b000);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are registered, so the reset mask must be combinational to silence the cycle rst arrives in.
    assign bus.InsRead    = ctrl_q.ins_read  & ~rst;
    assign bus.PCnext     = ctrl_q.pc_next   & ~rst;
    assign bus.MemRead    = ctrl_q.mem_read  & ~rst;
    assign bus.MemWrite   = ctrl_q.mem_write & ~rst;
    assign bus.RegWrite   = ctrl_q.reg_write & ~rst;
    assign bus.outEn      = ctrl_q.out_en    & ~rst;
    assign bus.ALUSrc     = ctrl_q.alu_src;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.ALUControl = ctrl_q.alu_ctl;
    // zero_flag reflects the SUB issued in this same EXEC cycle, so the branch select cannot be registered.
    assign bus.PCSrc      = ctrl_q.pc_src | {1'b0, ctrl_q.beq & bus.zero_flag};
    assign bus.halted     = ctrl_q.halted;
    assign bus.illegal    = illegal_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: the driver queues one expected output image per cycle,
// a forked monitor pops and compares it at the falling edge.
module tb_mips_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_control_fsm_if #(.BUS_WIDTH(16)) bus ();
    mips_control_fsm #(.BUS_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    // strobe field order: {InsRead, PCnext, MemRead, MemWrite, ALUSrc, RegWrite, outEn}
    localparam logic [6:0] S_INS = 7'b1000000;
    localparam logic [6:0] S_PCN = 7'b0100000;
    localparam logic [6:0] S_MR  = 7'b0010000;
    localparam logic [6:0] S_MW  = 7'b0001000;
    localparam logic [6:0] S_AS  = 7'b0000100;
    localparam logic [6:0] S_RW  = 7'b0000010;
    localparam logic [6:0] S_OE  = 7'b0000001;

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;
    logic [20:0] xf, xd;

    // {state, strobes, RegDst, PCSrc, MemtoReg, ALUControl, halted, illegal}
    function automatic logic [20:0] ex(input logic [2:0] st, input logic [6:0] strb,
                                       input logic [1:0] rd, input logic [1:0] ps,
                                       input logic [1:0] mtr, input logic [2:0] alu,
                                       input logic h, input logic il);
        return {st, strb, rd, ps, mtr, alu, h, il};
    endfunction

    task automatic step(input logic [15:0] ins, input logic zf, input logic r,
                        input logic [20:0] e, input string nm);
        @(posedge clk);
        #1;
        bus.instruction = ins;
        bus.zero_flag   = zf;
        rst             = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic front(input logic [15:0] ins, input logic zf, input string nm);
        step(ins, zf, 1'b0, xf, {nm, "_fetch"});
        step(ins, zf, 1'b0, xd, {nm, "_decode"});
    endtask

    task automatic monitor();
        logic [20:0] got;
        logic [20:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                got = {bus.state_dbg, bus.InsRead, bus.PCnext, bus.MemRead, bus.MemWrite,
                       bus.ALUSrc, bus.RegWrite, bus.outEn, bus.RegDst, bus.PCSrc,
                       bus.MemtoReg, bus.ALUControl, bus.halted, bus.illegal};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got=%h want=%h", n, got, e);
                end
            end
        end
    endtask

    initial begin
        bus.instruction = 16'h0000;
        bus.zero_flag   = 1'b0;
        xf = ex(3'd0, S_INS, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        xd = ex(3'd1, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        fork
            monitor();
        join_none

        step(16'h0000, 1'b0, 1'b1, ex(3'd0, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "reset");

        front(16'h0A5A, 1'b0, "rtype");
        step(16'h0A5A, 1'b0, 1'b0, ex(3'd2, S_PCN|S_RW, 2'b01, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0), "rtype_exec");

        front(16'h2283, 1'b0, "lw");
        step(16'h2283, 1'b0, 1'b0, ex(3'd2, S_MR|S_AS, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "lw_exec");
        step(16'h2283, 1'b0, 1'b0, ex(3'd3, S_PCN|S_AS|S_RW, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0), "lw_memwb");

        front(16'h4283, 1'b1, "beq_taken");
        step(16'h4283, 1'b1, 1'b0, ex(3'd2, S_PCN, 2'b00, 2'b01, 2'b00, 3'b001, 1'b0, 1'b0), "beq_taken_exec");
        front(16'h4283, 1'b0, "beq_not");
        step(16'h4283, 1'b0, 1'b0, ex(3'd2, S_PCN, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0), "beq_not_exec");

        front(16'h6010, 1'b0, "jal");
        step(16'h6010, 1'b0, 1'b0, ex(3'd2, S_PCN, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "jal_exec");
        step(16'h6010, 1'b0, 1'b0, ex(3'd4, S_PCN|S_RW, 2'b10, 2'b10, 2'b10, 3'b000, 1'b0, 1'b0), "jal_link");

        front(16'h3123, 1'b0, "sw");
        step(16'h3123, 1'b0, 1'b0, ex(3'd2, S_PCN|S_MW|S_AS, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "sw_exec");
        front(16'h5040, 1'b0, "j");
        step(16'h5040, 1'b0, 1'b0, ex(3'd2, S_PCN, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0), "j_exec");
        front(16'h7300, 1'b1, "jr");
        step(16'h7300, 1'b1, 1'b0, ex(3'd2, S_PCN, 2'b00, 2'b11, 2'b00, 3'b000, 1'b0, 1'b0), "jr_exec");
        front(16'h1007, 1'b0, "addi");
        step(16'h1007, 1'b0, 1'b0, ex(3'd2, S_PCN|S_AS|S_RW, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "addi_exec");
        front(16'h8200, 1'b0, "in");
        step(16'h8200, 1'b0, 1'b0, ex(3'd2, S_PCN|S_RW, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0, 1'b0), "in_exec");
        front(16'h9200, 1'b0, "out");
        step(16'h9200, 1'b0, 1'b0, ex(3'd2, S_PCN|S_OE, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "out_exec");

        front(16'h2283, 1'b0, "lw_rst");
        step(16'h2283, 1'b0, 1'b0, ex(3'd2, S_MR|S_AS, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "lw_rst_exec");
        step(16'h2283, 1'b0, 1'b1, ex(3'd3, S_AS, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0), "lw_rst_memwb_masked");
        step(16'h2283, 1'b0, 1'b0, xf, "lw_rst_refetch");

        step(16'hB000, 1'b0, 1'b0, xd, "illegal_decode");
        step(16'hB000, 1'b0, 1'b0, ex(3'd5, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1), "illegal_halt");
        step(16'hB000, 1'b0, 1'b0, ex(3'd5, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1), "illegal_hold");
        step(16'hB000, 1'b0, 1'b1, ex(3'd5, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1), "illegal_rst_cycle");
        step(16'hF000, 1'b0, 1'b0, xf, "illegal_cleared_fetch");

        step(16'hF000, 1'b0, 1'b0, xd, "halt_decode");
        step(16'hF000, 1'b0, 1'b0, ex(3'd2, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0), "halt_exec");
        step(16'hF000, 1'b0, 1'b0, ex(3'd5, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0), "halt_state");
        step(16'h0A5A, 1'b1, 1'b0, ex(3'd5, 7'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0), "halt_hold");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
